// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the write-back data cache and its lane logic.
package dcache_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } state_e;

    localparam int OFFSET_W = 2;

    function automatic int word_idx_w(input int words_per_line);
        return (words_per_line > 1) ? $clog2(words_per_line) : 0;
    endfunction

    function automatic int set_idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_width, input int num_sets, input int words_per_line);
        return addr_width - OFFSET_W - word_idx_w(words_per_line) - set_idx_w(num_sets);
    endfunction

endpackage

// File: rtl/dcache_lane_ctrl.sv
// Byte-lane steering: store byte enables/replication and load extract/extend.
// Shared with datamem so both sides agree on sub-word placement.
module dcache_lane_ctrl
    import dcache_pkg::*;
(
    input  logic [1:0]  type_control,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = load_word[{offset, 3'b000} +: 8];
    assign lane_h = offset[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        byte_en    = 4'b1111;
        store_word = store_data;
        load_data  = load_word;
        case (type_control)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << offset;
                store_word = {4{store_data[7:0]}};
                load_data  = sign_ext ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
            end
            SZ_HALF: begin
                // addr[0] is ignored: halfwords always land on an even lane pair
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_data  = sign_ext ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
            end
            default: begin
                byte_en    = 4'b1111;
                store_word = store_data;
                load_data  = load_word;
            end
        endcase
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache with word-serial refill and
// writeback. Define DCACHE_PERF_CNT_EN to add saturating hit/miss/writeback counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serve hits combinationally; a miss raises stall
// WRITEBACK | stream the dirty victim line out, word 0 first
// REFILL    | stream the requested line in, then mark it valid and clean
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SETS       = 256,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [1:0]            type_control,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
`endif
);

    localparam int WORD_W  = word_idx_w(WORDS_PER_LINE);
    localparam int CNT_W   = (WORD_W > 0) ? WORD_W : 1;
    localparam int SET_W   = set_idx_w(NUM_SETS);
    localparam int TAG_W   = tag_w(ADDR_WIDTH, NUM_SETS, WORDS_PER_LINE);
    localparam int SET_LSB = OFFSET_W + WORD_W;
    localparam int TAG_LSB = SET_LSB + SET_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    logic [TAG_W-1:0]      tag_arr  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_arr [NUM_SETS][WORDS_PER_LINE];

    logic [SET_W-1:0] set_idx;
    logic [CNT_W-1:0] word_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req;
    logic             is_store;
    logic             hit;
    logic             idle_hit;
    logic             xfer;
    logic             last_ack;

    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] store_word;
    logic [DATA_WIDTH-1:0] load_data;

    assign set_idx = addr[SET_LSB +: SET_W];
    assign req_tag = addr[ADDR_WIDTH-1:TAG_LSB];

    if (WORD_W > 0) begin : g_word_idx
        assign word_idx = addr[OFFSET_W +: CNT_W];
    end else begin : g_no_word_idx
        assign word_idx = '0;
    end

    assign req      = read_en | write_en;
    assign is_store = write_en;
    assign hit      = valid_q[set_idx] && (tag_arr[set_idx] == req_tag);
    assign idle_hit = (state_q == IDLE) && req && hit;
    assign xfer     = mem_req && mem_ack;
    assign last_ack = xfer && (cnt_q == LAST_WORD);

    dcache_lane_ctrl u_lane_ctrl (
        .type_control (type_control),
        .sign_ext     (sign_ext),
        .offset       (addr[1:0]),
        .store_data   (din),
        .load_word    (data_arr[set_idx][word_idx]),
        .byte_en      (byte_en),
        .store_word   (store_word),
        .load_data    (load_data)
    );

    function automatic logic [ADDR_WIDTH-1:0] line_word_addr(
        input logic [TAG_W-1:0] tag,
        input logic [SET_W-1:0] set,
        input logic [CNT_W-1:0] word
    );
        return (ADDR_WIDTH'(tag) << TAG_LSB) |
               (ADDR_WIDTH'(set) << SET_LSB) |
               (ADDR_WIDTH'(word) << OFFSET_W);
    endfunction

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        dout      = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (!is_store) dout = load_data;
                    end else begin
                        stall   = 1'b1;
                        state_d = (valid_q[set_idx] && dirty_q[set_idx]) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                // Victim tag is still in the tag array until the refill completes
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_word_addr(tag_arr[set_idx], set_idx, cnt_q);
                mem_wdata = data_arr[set_idx][cnt_q];
                if (last_ack) state_d = REFILL;
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = line_word_addr(req_tag, set_idx, cnt_q);
                if (last_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) cnt_q <= (cnt_q == LAST_WORD) ? '0 : cnt_q + CNT_W'(1);
            if (idle_hit && is_store) dirty_q[set_idx] <= 1'b1;
            if ((state_q == WRITEBACK) && last_ack) dirty_q[set_idx] <= 1'b0;
            if ((state_q == REFILL) && last_ack) begin
                valid_q[set_idx] <= 1'b1;
                dirty_q[set_idx] <= 1'b0;
            end
        end
    end

    // Storage arrays carry no reset; valid_q alone decides whether contents count.
    always_ff @(posedge clk) begin
        if (idle_hit && is_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) data_arr[set_idx][word_idx][8*b +: 8] <= store_word[8*b +: 8];
            end
        end
        if ((state_q == REFILL) && xfer) data_arr[set_idx][cnt_q] <= mem_rdata;
        if ((state_q == REFILL) && last_ack) tag_arr[set_idx] <= req_tag;
    end

`ifdef DCACHE_PERF_CNT_EN
    logic refill_done_q;

    // The held request that completes a refill is part of the miss, not a new hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refill_done_q <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
            wb_count      <= '0;
        end else begin
            refill_done_q <= (state_q == REFILL) && last_ack;
            if (idle_hit && !refill_done_q && (hit_count != '1)) hit_count <= hit_count + 32'd1;
            if ((state_q == IDLE) && req && !hit && (miss_count != '1))
                miss_count <= miss_count + 32'd1;
            if ((state_q == IDLE) && (state_d == WRITEBACK) && (wb_count != '1))
                wb_count <= wb_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Parametrised write-back, write-allocate, direct-mapped data cache with multi-word lines for the MEM stage.
- Successor to the single-word write-through cache: it adds configurable line size, dirty-line eviction and a handshaked, word-serial refill/writeback port to the backing datamem.
- Sits between the EXE/MEM pipeline register and main memory, and stalls the pipeline on misses.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 in this generation.
- NUM_SETS, 256, number of lines; power of 2, ≥2.
- WORDS_PER_LINE, 4, words per line; power of 2, ≥1.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- read_en  in  1  CPU load request.
- write_en  in  1  CPU store request; if read_en and write_en are both high, the access is treated as a store.
- type_control  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- sign_ext  in  1  sign-extend sub-word loads.
- addr  in  ADDR_WIDTH  byte address.
- din  in  DATA_WIDTH  store data, right-aligned.
- dout  out  DATA_WIDTH  load data, right-aligned and extended.
- stall  out  1  freeze pipeline while high.
- mem_req  out  1  word transfer request.
- mem_we  out  1  1 = writeback word, 0 = refill read.
- mem_addr  out  ADDR_WIDTH  word-aligned address.
- mem_wdata  out  DATA_WIDTH  writeback data.
- mem_ack  in  1  transfer complete this cycle.
- mem_rdata  in  DATA_WIDTH  refill data, valid when mem_ack is high.

Behaviour:
- Address split: offset[1:0] | word index [log2 WORDS_PER_LINE] | set index [log2 NUM_SETS] | tag (remaining bits).
- Sub-word alignment: halfwords use addr[1] and ignore addr[0]. There is no misalignment trap.
- Reset:
  - All valid and dirty bits are cleared and the FSM goes to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0, dout=0.
  - Data and tag arrays are not reset.
  - Reset during WRITEBACK or REFILL abandons the transfer; the memory side must tolerate a dropped request.
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE:
    - Hit (valid and tag match): dout is combinational in the same cycle and stall=0.
    - Store hit: the byte-enabled write happens on the clock edge and sets the dirty bit.
    - Miss: stall=1 combinationally in the same cycle. The next state is WRITEBACK if the victim is valid and dirty, otherwise REFILL.
    - No request: idle, stall=0.
  - WRITEBACK:
    - Issues WORDS_PER_LINE writes of the victim line, word 0 first, with mem_addr = {victim tag, set, word, 2'b00}.
    - Word counter increments on each mem_ack.
    - After the last ack: go to REFILL and clear the dirty bit.
  - REFILL:
    - Issues WORDS_PER_LINE reads at the requested line; each mem_rdata is written into the line on its ack.
    - After the last ack: write the tag, set valid, clear dirty, return to IDLE.
    - The still-held CPU request then hits in IDLE (one extra cycle with stall=0); a store then sets dirty.
  - stall is high in every WRITEBACK and REFILL cycle.
- Memory handshake:
  - mem_req and its address/data are held stable until mem_ack.
  - mem_req may stay high back-to-back; the address advances on the cycle after an ack.
  - mem_ack while mem_req=0 is ignored.
  - Zero-wait memory is allowed: ack may arrive in the same cycle as req.
- Load extension: bytes and halves are zero- or sign-extended per sign_ext. With no request, dout is 0.
- Word counter wraps at WORDS_PER_LINE-1 back to 0.
- CPU inputs must be held while stall=1; the pipeline guarantees this.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- When defined, adds three outputs: hit_count (32), miss_count (32) and wb_count (32).
  - Saturating counters, reset to 0.
  - A hit counts once per IDLE hit cycle with a request, excluding the post-refill completion cycle.
  - A miss counts on the IDLE→miss transition.
  - wb_count counts each line eviction.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - the access-size enum (BYTE/HALF/WORD);
  - the state enum (IDLE, WRITEBACK, REFILL);
  - localparam functions for offset, index and tag widths.
- One sub-module, dcache_lane_ctrl: combinational byte-enable generation for stores and extract/extend for loads. It is reused by datamem.

Test Plan:
- After reset, load word at 0x100 with 2-cycle memory: stall high until the 4th ack, mem_addr runs 0x100, 0x104, 0x108, 0x10C. Next cycle dout=mem word at 0x100 and stall=0. A repeat load hits with no mem_req.
- Store byte 0xAB at 0x101 after the line is filled with 0x11223344: load word → 0x1122AB44. Load byte signed → 0xFFFFFFAB. Load byte unsigned → 0x000000AB.
- Dirty eviction: store 0xDEADBEEF to 0x100, then load 0x100+NUM_SETS*16 (0x1100 with defaults). Expect 4 writes at 0x100..0x10C with word 0 = 0xDEADBEEF, then 4 reads at 0x1100..0x110C.
- Clean miss: load a conflicting address with the victim not dirty → no mem_we cycles, refill only.
- Assert rst mid-REFILL after the 2nd ack: mem_req drops immediately and the FSM is in IDLE. Reloading the same address misses again.
- Zero-wait memory (ack tied to req): refill completes in 4 cycles. With DCACHE_PERF_CNT_EN defined, hit/miss/wb counts match the totals from the scenarios above.
